// File: rtl/z80_bus_tracer.sv
// Passive tv80s bus monitor: folds each completed bus cycle into a {type, addr, data}
// record and queues it in a show-ahead FIFO for the bench to inspect.
module z80_bus_tracer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    trace_en,
    input  logic                    clear,
    input  logic                    m1_n,
    input  logic                    mreq_n,
    input  logic                    iorq_n,
    input  logic                    rd_n,
    input  logic                    wr_n,
    input  logic                    rfsh_n,
    input  logic [15:0]             A,
    input  logic [7:0]              di,
    input  logic [7:0]              dout,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [2:0]              rec_type,
    output logic [15:0]             rec_addr,
    output logic [7:0]              rec_data,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [CNT_W-1:0]        m1_count,
    output logic [7:0]              drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = 27;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [2:0] TY_FETCH  = 3'd0;
    localparam logic [2:0] TY_MEMRD  = 3'd1;
    localparam logic [2:0] TY_MEMWR  = 3'd2;
    localparam logic [2:0] TY_IORD   = 3'd3;
    localparam logic [2:0] TY_IOWR   = 3'd4;
    localparam logic [2:0] TY_RFSH   = 3'd5;
    localparam logic [2:0] TY_INTACK = 3'd6;

    logic [0:0]       state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             is_m1_q, is_m1_d;
    logic             is_rfsh_q, is_rfsh_d;
    logic             is_iorq_q, is_iorq_d;
    logic             seen_wr_q, seen_wr_d;
    logic             rfsh_n_prev_q, mreq_n_prev_q;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]    head_q, head_d;
    logic [RW-1:0]    mem_q [DEPTH];
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] m1_count_q, m1_count_d;
    logic [7:0]       drop_count_q, drop_count_d;

    logic             req;
    logic             rfsh_fall;
    logic [7:0]       cur_data;
    logic             cur_seen_wr;
    logic [2:0]       cur_type;
    logic [RW-1:0]    push_rec;
    logic             push;
    logic             pop;
    logic             do_push;
    logic             drop;
    logic             mem_we;
    logic [AW:0]      level;
    logic             full;

    assign req       = !mreq_n || !iorq_n;
    assign rfsh_fall = !rfsh_n && rfsh_n_prev_q && !mreq_n && !mreq_n_prev_q;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign full      = (level == FULL_LVL);

    // Data/strobe view including this edge's sample, so a commit edge sees the latest strobe.
    always_comb begin
        cur_data    = data_q;
        cur_seen_wr = seen_wr_q;
        if (!rd_n) begin
            cur_data = di;
        end
        if (!wr_n) begin
            cur_data    = dout;
            cur_seen_wr = 1'b1;
        end
    end

    always_comb begin
        if (is_rfsh_q) begin
            cur_type = TY_RFSH;
        end else if (is_m1_q && is_iorq_q) begin
            cur_type = TY_INTACK;
        end else if (is_m1_q) begin
            cur_type = TY_FETCH;
        end else if (is_iorq_q) begin
            cur_type = cur_seen_wr ? TY_IOWR : TY_IORD;
        end else begin
            cur_type = cur_seen_wr ? TY_MEMWR : TY_MEMRD;
        end
    end

    assign push_rec = {cur_type, addr_q, is_rfsh_q ? 8'h00 : cur_data};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        is_m1_d   = is_m1_q;
        is_rfsh_d = is_rfsh_q;
        is_iorq_d = is_iorq_q;
        seen_wr_d = seen_wr_q;
        push      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req && trace_en) begin
                    state_d   = ST_ACTIVE;
                    addr_d    = A;
                    is_m1_d   = !m1_n;
                    is_rfsh_d = !rfsh_n;
                    is_iorq_d = !iorq_n;
                    data_d    = 8'h00;
                    seen_wr_d = 1'b0;
                end
            end
            default: begin
                data_d    = cur_data;
                seen_wr_d = cur_seen_wr;
                if (!req) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end else if (rfsh_fall) begin
                    // Refresh follows M1 without mreq_n releasing: split into a second record.
                    push      = 1'b1;
                    addr_d    = A;
                    is_m1_d   = 1'b0;
                    is_rfsh_d = 1'b1;
                    is_iorq_d = 1'b0;
                    data_d    = 8'h00;
                    seen_wr_d = 1'b0;
                end
            end
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        pop          = (level != '0) && rec_ready;
        do_push      = push && (!full || pop);
        drop         = push && full && !pop;
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop};
        head_d       = head_q;
        overflow_d   = overflow_q | drop;
        m1_count_d   = m1_count_q;
        drop_count_d = drop_count_q;
        mem_we       = do_push && !clear;
        if (do_push && (push_rec[26:24] == TY_FETCH)) begin
            m1_count_d = m1_count_q + CNT_W'(1);
        end
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
        // Head comes from the pushed record when it lands in an otherwise empty slot.
        if (wr_ptr_d != rd_ptr_d) begin
            if (rd_ptr_d == wr_ptr_q) begin
                head_d = push_rec;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            head_d       = '0;
            overflow_d   = 1'b0;
            m1_count_d   = '0;
            drop_count_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= 16'h0000;
            data_q        <= 8'h00;
            is_m1_q       <= 1'b0;
            is_rfsh_q     <= 1'b0;
            is_iorq_q     <= 1'b0;
            seen_wr_q     <= 1'b0;
            rfsh_n_prev_q <= 1'b1;
            mreq_n_prev_q <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            head_q        <= '0;
            overflow_q    <= 1'b0;
            m1_count_q    <= '0;
            drop_count_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            is_m1_q       <= is_m1_d;
            is_rfsh_q     <= is_rfsh_d;
            is_iorq_q     <= is_iorq_d;
            seen_wr_q     <= seen_wr_d;
            rfsh_n_prev_q <= rfsh_n;
            mreq_n_prev_q <= mreq_n;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            head_q        <= head_d;
            overflow_q    <= overflow_d;
            m1_count_q    <= m1_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign rec_valid  = (level != '0);
    assign rec_type   = head_q[26:24];
    assign rec_addr   = head_q[23:8];
    assign rec_data   = head_q[7:0];
    assign fifo_level = level;
    assign overflow   = overflow_q;
    assign m1_count   = m1_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Directed bench for z80_bus_tracer: emulates tv80s bus cycles and checks the record stream.
module tb_z80_bus_tracer;

    localparam logic [2:0] T_FETCH = 3'd0;
    localparam logic [2:0] T_MEMRD = 3'd1;
    localparam logic [2:0] T_MEMWR = 3'd2;
    localparam logic [2:0] T_IORD  = 3'd3;
    localparam logic [2:0] T_IOWR  = 3'd4;
    localparam logic [2:0] T_RFSH  = 3'd5;

    logic        clk = 1'b0;
    logic        reset_n, trace_en, clear;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] A;
    logic [7:0]  di, dout;
    logic        rec_valid, rec_ready;
    logic [2:0]  rec_type;
    logic [15:0] rec_addr;
    logic [7:0]  rec_data;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [31:0] m1_count;
    logic [7:0]  drop_count;

    logic [7:0]  mem [0:65535];
    logic [7:0]  iomem [0:255];
    logic [7:0]  r_reg;
    logic [26:0] got_q[$];
    logic [26:0] exp_q[$];
    int          n_tot = 0;
    int          n_bad = 0;

    z80_bus_tracer #(.DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .trace_en(trace_en), .clear(clear),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .rfsh_n(rfsh_n), .A(A), .di(di), .dout(dout),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
        .rec_addr(rec_addr), .rec_data(rec_data), .fifo_level(fifo_level),
        .overflow(overflow), .m1_count(m1_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Each negedge with valid & ready is exactly one pop at the following posedge.
    always @(negedge clk) begin
        if (reset_n && rec_valid && rec_ready) got_q.push_back({rec_type, rec_addr, rec_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_idle();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic bus_rw(input logic io, input logic wr, input logic [15:0] a,
                          input logic [7:0] d);
        A = a;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        if (wr) dout = d;
        else begin
            rd_n = 1'b0;
            di   = io ? iomem[a[7:0]] : mem[a];
        end
        step();
        if (wr) wr_n = 1'b0;
        step();
        if (wr && io) iomem[a[7:0]] = d;
        else if (wr) mem[a] = d;
        bus_idle();
        step();
    endtask

    task automatic fetch(input logic [15:0] a);
        A = a; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; di = mem[a];
        step();
        step();
        m1_n = 1'b1; rd_n = 1'b1; rfsh_n = 1'b0; A = {8'h00, r_reg};
        step();
        step();
        bus_idle();
        step();
        r_reg = r_reg + 8'd1;
    endtask

    task automatic expect_rec(input logic [2:0] ty, input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({ty, a, d});
    endtask

    task automatic drain();
        rec_ready = 1'b1;
        for (int i = 0; i < 40 && rec_valid; i++) step();
        check("drain empty", 32'(rec_valid), 32'd0);
        rec_ready = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s rec%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " valid"}, 32'(rec_valid), 32'd0);
        check({tag, " level"}, 32'(fifo_level), 32'd0);
        check({tag, " ovf"}, 32'(overflow), 32'd0);
        check({tag, " m1cnt"}, m1_count, 32'd0);
        check({tag, " dropcnt"}, 32'(drop_count), 32'd0);
        check({tag, " type"}, 32'(rec_type), 32'd0);
        check({tag, " addr"}, 32'(rec_addr), 32'd0);
        check({tag, " data"}, 32'(rec_data), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) iomem[i] = 8'h00;
        mem[16'h0000] = 8'hDD; mem[16'h0001] = 8'hA5; mem[16'h0002] = 8'h32;
        mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h80; mem[16'h0005] = 8'hD3;
        mem[16'h0006] = 8'h12; mem[16'h0007] = 8'hDB; mem[16'h0008] = 8'h12;
        mem[16'h0009] = 8'h00; mem[16'h000A] = 8'h3E; mem[16'h000B] = 8'h44;
        for (int i = 0; i < 8; i++) begin
            mem[16'h0100 + 16'(i)] = 8'h10 + 8'(i);
            mem[16'h0200 + 16'(i)] = 8'h20 + 8'(i);
        end
        mem[16'h0300] = 8'h30; mem[16'h0301] = 8'h31;
        r_reg = 8'h00;
        reset_n = 1'b0; trace_en = 1'b1; clear = 1'b0; rec_ready = 1'b0;
        A = 16'h0000; di = 8'h00; dout = 8'h00;
        bus_idle();
        step();
        step();
        check_reset_vals("reset");
        reset_n = 1'b1;
        step();

        // 1: two fetches with refresh, consumer always ready
        rec_ready = 1'b1;
        fetch(16'h0000);
        fetch(16'h0001);
        expect_rec(T_FETCH, 16'h0000, 8'hDD);
        expect_rec(T_RFSH,  16'h0000, 8'h00);
        expect_rec(T_FETCH, 16'h0001, 8'hA5);
        expect_rec(T_RFSH,  16'h0001, 8'h00);
        drain();
        compare_q("t1");
        check("t1 m1cnt", m1_count, 32'd2);

        // 2: LD (8000),A with A=5A
        rec_ready = 1'b1;
        fetch(16'h0002);
        bus_rw(1'b0, 1'b0, 16'h0003, 8'h00);
        bus_rw(1'b0, 1'b0, 16'h0004, 8'h00);
        bus_rw(1'b0, 1'b1, 16'h8000, 8'h5A);
        expect_rec(T_FETCH, 16'h0002, 8'h32);
        expect_rec(T_RFSH,  16'h0002, 8'h00);
        expect_rec(T_MEMRD, 16'h0003, 8'h00);
        expect_rec(T_MEMRD, 16'h0004, 8'h80);
        expect_rec(T_MEMWR, 16'h8000, 8'h5A);
        drain();
        n = 0;
        foreach (got_q[i]) if (got_q[i][26:24] == T_MEMRD && got_q[i][23:8] == 16'h8000) n++;
        check("t2 no rd 8000", 32'(n), 32'd0);
        compare_q("t2");

        // 3: OUT (12),A then IN A,(12)
        rec_ready = 1'b1;
        fetch(16'h0005);
        bus_rw(1'b0, 1'b0, 16'h0006, 8'h00);
        bus_rw(1'b1, 1'b1, 16'h0012, 8'h3C);
        fetch(16'h0007);
        bus_rw(1'b0, 1'b0, 16'h0008, 8'h00);
        bus_rw(1'b1, 1'b0, 16'h0012, 8'h00);
        expect_rec(T_FETCH, 16'h0005, 8'hD3);
        expect_rec(T_RFSH,  16'h0003, 8'h00);
        expect_rec(T_MEMRD, 16'h0006, 8'h12);
        expect_rec(T_IOWR,  16'h0012, 8'h3C);
        expect_rec(T_FETCH, 16'h0007, 8'hDB);
        expect_rec(T_RFSH,  16'h0004, 8'h00);
        expect_rec(T_MEMRD, 16'h0008, 8'h12);
        expect_rec(T_IORD,  16'h0012, 8'h3C);
        drain();
        compare_q("t3");
        check("t3 m1cnt", m1_count, 32'd5);

        // 4: overflow with consumer stalled, then in-order drain
        pulse_clear();
        check("t4 m1cnt clr", m1_count, 32'd0);
        rec_ready = 1'b0;
        for (int i = 0; i < 6; i++) bus_rw(1'b0, 1'b0, 16'h0100 + 16'(i), 8'h00);
        check("t4 level", 32'(fifo_level), 32'd4);
        check("t4 ovf", 32'(overflow), 32'd1);
        check("t4 dropcnt", 32'(drop_count), 32'd2);
        check("t4 head addr", 32'(rec_addr), 32'h0100);
        for (int i = 0; i < 4; i++) expect_rec(T_MEMRD, 16'h0100 + 16'(i), 8'h10 + 8'(i));
        drain();
        compare_q("t4");
        check("t4 level empty", 32'(fifo_level), 32'd0);

        // 4b: drop counter saturates
        pulse_clear();
        for (int i = 0; i < 260; i++) bus_rw(1'b0, 1'b0, 16'h0100, 8'h00);
        check("t4b dropcnt sat", 32'(drop_count), 32'hFF);
        check("t4b ovf", 32'(overflow), 32'd1);
        pulse_clear();
        check("t4b dropcnt clr", 32'(drop_count), 32'd0);
        check("t4b ovf clr", 32'(overflow), 32'd0);

        // 5: full FIFO, push and pop on the same edge
        for (int i = 0; i < 4; i++) bus_rw(1'b0, 1'b0, 16'h0200 + 16'(i), 8'h00);
        check("t5 level full", 32'(fifo_level), 32'd4);
        A = 16'h0204; mreq_n = 1'b0; rd_n = 1'b0; di = mem[16'h0204];
        step();
        step();
        bus_idle();
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        check("t5 level", 32'(fifo_level), 32'd4);
        check("t5 ovf", 32'(overflow), 32'd0);
        check("t5 dropcnt", 32'(drop_count), 32'd0);
        for (int i = 0; i < 5; i++) expect_rec(T_MEMRD, 16'h0200 + 16'(i), 8'h20 + 8'(i));
        drain();
        compare_q("t5");

        // trace_en gating: no new start, in-flight record still commits
        trace_en = 1'b0;
        bus_rw(1'b0, 1'b0, 16'h0300, 8'h00);
        check("ten off level", 32'(fifo_level), 32'd0);
        trace_en = 1'b1;
        A = 16'h0301; mreq_n = 1'b0; rd_n = 1'b0; di = mem[16'h0301];
        step();
        trace_en = 1'b0;
        step();
        bus_idle();
        step();
        check("ten inflight level", 32'(fifo_level), 32'd1);
        trace_en = 1'b1;
        expect_rec(T_MEMRD, 16'h0301, 8'h31);
        drain();
        compare_q("ten");

        // 6: async reset in the middle of a MEMWR
        fetch(16'h0009);
        A = 16'h8001; mreq_n = 1'b0; dout = 8'h77;
        step();
        wr_n = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check_reset_vals("t6 rst");
        bus_idle();
        step();
        reset_n = 1'b1;
        step();
        step();
        check("t6 level post", 32'(fifo_level), 32'd0);
        check("t6 valid post", 32'(rec_valid), 32'd0);

        // 6b: clear with three records queued
        fetch(16'h000A);
        bus_rw(1'b0, 1'b0, 16'h000B, 8'h00);
        check("t6b level", 32'(fifo_level), 32'd3);
        check("t6b m1cnt", m1_count, 32'd1);
        pulse_clear();
        check("t6b level clr", 32'(fifo_level), 32'd0);
        check("t6b valid clr", 32'(rec_valid), 32'd0);
        check("t6b m1cnt clr", m1_count, 32'd0);
        check("t6b ovf clr", 32'(overflow), 32'd0);
        got_q.delete();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
